rsa_modexp_engine: RTL and testbench



---
 rtl/rsa_pkg.sv | 7 +
 rtl/rsa_modmul_seq.sv | 63 ++++++
 rtl/rsa_modexp_engine.sv | 153 +++++++++++++++
 tb/tb_rsa_modexp_engine.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation engine: FSM states and default operand widths.
package rsa_pkg;
  localparam int RSA_WIDTH_DEFAULT     = 256;
  localparam int RSA_EXP_WIDTH_DEFAULT = 256;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, MUL_R, MUL_B, DONE} rsa_state_t;
endpackage

// File: rtl/rsa_modmul_seq.sv
// Sequential a*b mod n (MSB-first interleaved shift-add); start to done is WIDTH+1 cycles.
// No backpressure: done pulses for one cycle and p holds until the next start.
module rsa_modmul_seq #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [WIDTH+1:0] acc_q, acc_d, sum, sub1, n_ext;
  logic [CW-1:0]    cnt_q;
  logic             run_q, done_q;

  // acc < n and b < n, so 2*acc + b < 3n: two conditional subtractions restore acc < n.
  always_comb begin
    n_ext = {2'b00, n_q};
    sum   = (acc_q << 1) + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    sub1  = (sum >= n_ext) ? (sum - n_ext) : sum;
    acc_d = (sub1 >= n_ext) ? (sub1 - n_ext) : sub1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      n_q    <= n;
      acc_q  <= '0;
      cnt_q  <= CW'(WIDTH);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run_q) begin
        acc_q <= acc_d;
        a_q   <= a_q << 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign p    = acc_q[WIDTH-1:0];
endmodule

// File: rtl/rsa_modexp_engine.sv
// M^E mod N by right-to-left square-and-multiply; latency 3 + muls*(WIDTH+1) + checks, result held until out_ready.
// Optional RSA_MODEXP_INPUT_CHECK_EN adds the err port and rejects N==0 or M>=N at capture.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = RSA_WIDTH_DEFAULT,
  parameter int EXP_WIDTH = RSA_EXP_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     message,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 busy
`ifdef RSA_MODEXP_INPUT_CHECK_EN
  ,
  output logic                 err
`endif
);
  rsa_state_t           state_q, state_d;
  logic [WIDTH-1:0]     r_q, r_d, b_q, b_d, n_q, n_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic                 mul_start, mul_sel_r, mul_done;
  logic [WIDTH-1:0]     mul_a, mul_p;

`ifdef RSA_MODEXP_INPUT_CHECK_EN
  logic err_q, err_d, bad_operands;
  assign bad_operands = (modulus == '0) || (message >= modulus);
  assign err          = err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      e_q     <= '0;
`ifdef RSA_MODEXP_INPUT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      b_q     <= b_d;
      n_q     <= n_d;
      e_q     <= e_d;
`ifdef RSA_MODEXP_INPUT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    b_d       = b_q;
    n_d       = n_q;
    e_d       = e_q;
    mul_start = 1'b0;
    mul_sel_r = 1'b0;
`ifdef RSA_MODEXP_INPUT_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          b_d     = message;
          e_d     = exponent;
          n_d     = modulus;
          state_d = LOAD;
`ifdef RSA_MODEXP_INPUT_CHECK_EN
          err_d = 1'b0;
          if (bad_operands) begin
            r_d     = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      LOAD: begin
        r_d     = (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
        state_d = CHECK;
      end
      CHECK: begin
        if (e_q == '0) begin
          state_d = DONE;
        end else begin
          mul_start = 1'b1;
          if (e_q[0]) begin
            mul_sel_r = 1'b1;
            state_d   = MUL_R;
          end else begin
            state_d = MUL_B;
          end
        end
      end
      MUL_R: begin
        if (mul_done) begin
          r_d = mul_p;
          // Skip the final squaring once no exponent bits remain above this one.
          if (e_q[EXP_WIDTH-1:1] != '0) begin
            mul_start = 1'b1;
            state_d   = MUL_B;
          end else begin
            state_d = DONE;
          end
        end
      end
      MUL_B: begin
        if (mul_done) begin
          b_d     = mul_p;
          e_d     = e_q >> 1;
          state_d = CHECK;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef RSA_MODEXP_INPUT_CHECK_EN
          err_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Both products share B as the second operand; only the first operand switches.
  assign mul_a = mul_sel_r ? r_q : b_q;

  rsa_modmul_seq #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (mul_a),
    .b     (b_q),
    .n     (n_q),
    .done  (mul_done),
    .p     (mul_p)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = r_q;
endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine: a 256-bit instance and a 16-bit instance side by side.
module tb_rsa_modexp_engine;
  logic clk = 1'b0;
  logic rst;

  logic         iv256, ir256, ov256, or256, busy256;
  logic [255:0] m256, e256, n256, res256;
  logic         iv16, ir16, ov16, or16, busy16;
  logic [15:0]  m16, e16, n16, res16;
`ifdef RSA_MODEXP_INPUT_CHECK_EN
  logic         err256, err16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rsa_modexp_engine #(.WIDTH(256), .EXP_WIDTH(256)) u_dut256 (
    .clk(clk), .reset(rst), .in_valid(iv256), .in_ready(ir256),
    .message(m256), .exponent(e256), .modulus(n256),
    .out_valid(ov256), .out_ready(or256), .result(res256), .busy(busy256)
`ifdef RSA_MODEXP_INPUT_CHECK_EN
    , .err(err256)
`endif
  );

  rsa_modexp_engine #(.WIDTH(16), .EXP_WIDTH(16)) u_dut16 (
    .clk(clk), .reset(rst), .in_valid(iv16), .in_ready(ir16),
    .message(m16), .exponent(e16), .modulus(n16),
    .out_valid(ov16), .out_ready(or16), .result(res16), .busy(busy16)
`ifdef RSA_MODEXP_INPUT_CHECK_EN
    , .err(err16)
`endif
  );

  task automatic start_op16(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n,
                            input logic ordy);
    @(negedge clk);
    m16 = m; e16 = e; n16 = n; or16 = ordy; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  // cyc counts cycles inclusively from the capture cycle to the first out_valid cycle.
  task automatic wait_ov16(output int cyc, output bit to);
    cyc = 2;
    while (ov16 !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = (ov16 !== 1'b1);
  endtask

  task automatic run_op16(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n,
                          output logic [15:0] res, output int cyc, output bit to,
                          output logic post_ov, output logic post_ir);
    start_op16(m, e, n, 1'b1);
    wait_ov16(cyc, to);
    res = res16;
    @(posedge clk); #1;
    post_ov = ov16;
    post_ir = ir16;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv256 = 1'b0; or256 = 1'b0; m256 = '0; e256 = '0; n256 = '0;
    iv16 = 1'b0; or16 = 1'b0; m16 = '0; e16 = '0; n16 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready16: got %b expected 1", ir16); end
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid16: got %b expected 0", ov16); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
    n_checks++; if (res16 !== 16'd0) begin n_fail++; $display("FAIL reset_result16: got %0d expected 0", res16); end
    n_checks++; if (ir256 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready256: got %b expected 1", ir256); end
    n_checks++; if (ov256 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid256: got %b expected 0", ov256); end
    n_checks++; if (busy256 !== 1'b0) begin n_fail++; $display("FAIL reset_busy256: got %b expected 0", busy256); end
    n_checks++; if (res256 !== 256'd0) begin n_fail++; $display("FAIL reset_result256: got %0h expected 0", res256); end
`ifdef RSA_MODEXP_INPUT_CHECK_EN
    n_checks++; if (err16 !== 1'b0) begin n_fail++; $display("FAIL reset_err16: got %b expected 0", err16); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_256;
    int cyc;
    bit hs_bad;
    @(negedge clk);
    m256 = 256'h12; e256 = 256'd5; n256 = 256'd35; or256 = 1'b1; iv256 = 1'b1;
    @(posedge clk); #1;
    iv256 = 1'b0;
    cyc = 2; hs_bad = 1'b0;
    while (ov256 !== 1'b1 && cyc < 5000) begin
      if (busy256 !== 1'b1 || ir256 !== 1'b0) hs_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (ov256 !== 1'b1) begin n_fail++; $display("FAIL w256_timeout: out_valid %b after %0d cycles, expected 1", ov256, cyc); end
    n_checks++; if (res256 !== 256'h17) begin n_fail++; $display("FAIL w256_result: got %0h expected 17", res256); end
    n_checks++; if (cyc != 1034) begin n_fail++; $display("FAIL w256_latency: got %0d expected 1034", cyc); end
    n_checks++; if (hs_bad || busy256 !== 1'b1 || ir256 !== 1'b0) begin n_fail++; $display("FAIL w256_busy_ready: glitch %b busy %b in_ready %b expected 0/1/0", hs_bad, busy256, ir256); end
    @(posedge clk); #1;
    n_checks++; if (ov256 !== 1'b0 || ir256 !== 1'b1 || busy256 !== 1'b0) begin n_fail++; $display("FAIL w256_transfer: out_valid %b in_ready %b busy %b expected 0/1/0", ov256, ir256, busy256); end
  endtask

  task automatic test_latency_16;
    logic [15:0] res; int cyc; bit to; logic pov, pir;
    run_op16(16'd4, 16'd13, 16'd497, res, cyc, to, pov, pir);
    n_checks++; if (to) begin n_fail++; $display("FAIL lat16_timeout: no out_valid after %0d cycles", cyc); end
    n_checks++; if (res !== 16'd445) begin n_fail++; $display("FAIL lat16_result: got %0d expected 445", res); end
    n_checks++; if (cyc != 109) begin n_fail++; $display("FAIL lat16_latency: got %0d expected 109", cyc); end
    n_checks++; if (pov !== 1'b0 || pir !== 1'b1) begin n_fail++; $display("FAIL lat16_first_cycle_transfer: out_valid %b in_ready %b expected 0/1", pov, pir); end
  endtask

  task automatic test_boundaries;
    logic [15:0] res; int cyc; bit to; logic pov, pir;
    run_op16(16'd9, 16'd0, 16'd35, res, cyc, to, pov, pir);
    n_checks++; if (to || res !== 16'd1) begin n_fail++; $display("FAIL e0_result: got %0d (timeout %b) expected 1", res, to); end
    n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL e0_latency: got %0d expected 4", cyc); end
    run_op16(16'd0, 16'd0, 16'd1, res, cyc, to, pov, pir);
    n_checks++; if (to || res !== 16'd0) begin n_fail++; $display("FAIL e0_n1_result: got %0d (timeout %b) expected 0", res, to); end
    run_op16(16'd0, 16'd7, 16'd35, res, cyc, to, pov, pir);
    n_checks++; if (to || res !== 16'd0) begin n_fail++; $display("FAIL m0_result: got %0d (timeout %b) expected 0", res, to); end
  endtask

  task automatic test_backpressure;
    int cyc; bit to;
    start_op16(16'd3, 16'd4, 16'd35, 1'b0);
    wait_ov16(cyc, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout: no out_valid after %0d cycles", cyc); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      iv16 = i[0]; m16 = 16'd7; e16 = 16'd1; n16 = 16'd9;
      @(posedge clk); #1;
      n_checks++;
      if (ov16 !== 1'b1 || res16 !== 16'd11 || ir16 !== 1'b0 || busy16 !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid %b result %0d in_ready %b busy %b expected 1/11/0/1", i, ov16, res16, ir16, busy16);
      end
    end
    @(negedge clk);
    iv16 = 1'b0; or16 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ov16 !== 1'b0 || ir16 !== 1'b1) begin n_fail++; $display("FAIL bp_release: out_valid %b in_ready %b expected 0/1", ov16, ir16); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ov16 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("FAIL bp_no_queue: out_valid %b busy %b expected 0/0", ov16, busy16); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] res; int cyc; bit to; logic pov, pir;
    start_op16(16'd5, 16'd6, 16'd35, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ir16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("FAIL abort: in_ready %b out_valid %b busy %b expected 1/0/0", ir16, ov16, busy16); end
    @(negedge clk);
    rst = 1'b0;
    run_op16(16'd2, 16'd10, 16'd1000, res, cyc, to, pov, pir);
    n_checks++; if (to || res !== 16'd24) begin n_fail++; $display("FAIL after_abort_result: got %0d (timeout %b) expected 24", res, to); end
  endtask

`ifdef RSA_MODEXP_INPUT_CHECK_EN
  task automatic test_input_check;
    int cyc; bit to;
    start_op16(16'd40, 16'd3, 16'd35, 1'b0);
    wait_ov16(cyc, to);
    n_checks++; if (to || cyc != 2) begin n_fail++; $display("FAIL chk_m_ge_n_latency: got %0d (timeout %b) expected 2", cyc, to); end
    n_checks++; if (err16 !== 1'b1 || res16 !== 16'd0) begin n_fail++; $display("FAIL chk_m_ge_n: err %b result %0d expected 1/0", err16, res16); end
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (err16 !== 1'b0 || ov16 !== 1'b0) begin n_fail++; $display("FAIL chk_err_clear: err %b out_valid %b expected 0/0", err16, ov16); end
    start_op16(16'd5, 16'd3, 16'd0, 1'b0);
    wait_ov16(cyc, to);
    n_checks++; if (to || cyc != 2 || err16 !== 1'b1 || res16 !== 16'd0) begin n_fail++; $display("FAIL chk_n0: cycles %0d err %b result %0d expected 2/1/0", cyc, err16, res16); end
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1;
    start_op16(16'd3, 16'd4, 16'd35, 1'b0);
    wait_ov16(cyc, to);
    n_checks++; if (to || err16 !== 1'b0 || res16 !== 16'd11) begin n_fail++; $display("FAIL chk_valid_op: err %b result %0d expected 0/11", err16, res16); end
    @(negedge clk); or16 = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_256();
    test_latency_16();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
`ifdef RSA_MODEXP_INPUT_CHECK_EN
    test_input_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
